// File: rtl/jc_pkg.sv
// Shared constants and types for the jump/branch/interrupt control unit.
// Default sizes, opcodes, FSM state encoding and the return-stack entry layout.
package jc_pkg;

   localparam int              JC_ADDR_W    = 16;
   localparam int              JC_N_IRQ     = 4;
   localparam int              JC_RAS_DEPTH = 4;
   localparam logic [15:0]     JC_VEC_BASE  = 16'hFF00;

   localparam logic [5:0] OP_JMP  = 6'b011000;
   localparam logic [5:0] OP_JC   = 6'b011100;
   localparam logic [5:0] OP_JZ   = 6'b011110;
   localparam logic [5:0] OP_CALL = 6'b011001;
   localparam logic [5:0] OP_RET  = 6'b011010;
   localparam logic [5:0] OP_RETI = 6'b011011;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } jc_state_t;

   // A CALL stores zero flags; an interrupt stores the live execute flags.
   typedef struct packed {
      logic [1:0]           flags;
      logic [JC_ADDR_W-1:0] addr;
   } ras_entry_t;

endpackage

// File: rtl/jump_ctrl_unit_if.sv
// Signal bundle between the pipeline front end and the jump control unit.
// The front end drives the instruction/flag/irq side and observes the redirect side.
interface jump_ctrl_unit_if
   import jc_pkg::*;
#(
   parameter int ADDR_W = JC_ADDR_W,
   parameter int N_IRQ  = JC_N_IRQ
) ();

   logic [ADDR_W-1:0] current_address;
   logic [ADDR_W-1:0] jmp_address_pm;
   logic [5:0]        op;
   logic [1:0]        flag_ex;
   logic [N_IRQ-1:0]  irq;

   logic [ADDR_W-1:0] jmp_loc;
   logic              pc_mux_sel;
   logic [N_IRQ-1:0]  irq_ack;
   logic [1:0]        flag_restore;
   logic              flag_restore_en;
   logic              in_isr;
   logic              ras_err;

   modport master (
      output current_address, jmp_address_pm, op, flag_ex, irq,
      input  jmp_loc, pc_mux_sel, irq_ack, flag_restore, flag_restore_en, in_isr, ras_err
   );

   modport slave (
      input  current_address, jmp_address_pm, op, flag_ex, irq,
      output jmp_loc, pc_mux_sel, irq_ack, flag_restore, flag_restore_en, in_isr, ras_err
   );

endinterface

// File: rtl/jc_ras.sv
// Return-address stack: a small LIFO with combinational top-of-stack read.
// At most one push or pop takes effect per cycle; push to full / pop from empty is ignored.
module jc_ras #(
   parameter int DATA_W = 18,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic              pop,
   input  logic [DATA_W-1:0] push_data,
   output logic [DATA_W-1:0] top_data,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  count;
   logic [PTR_W-2:0]  top_idx;

   assign full     = (count == PTR_W'(DEPTH));
   assign empty    = (count == '0);
   assign top_idx  = count[PTR_W-2:0] - (PTR_W-1)'(1);
   assign top_data = mem[top_idx];

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (push && !full) begin
         count <= count + PTR_W'(1);
      end else if (pop && !empty) begin
         count <= count - PTR_W'(1);
      end
   end

   // Storage is left unreset; only the occupancy count defines valid entries.
   always_ff @(posedge clk) begin
      if (reset && push && !full) begin
         mem[count[PTR_W-2:0]] <= push_data;
      end
   end

endmodule

// File: rtl/jump_ctrl_unit.sv
// Jump control unit: decodes jumps/calls/returns, takes edge-triggered interrupts,
// and issues registered PC redirects followed by a one-cycle flush.
module jump_ctrl_unit
   import jc_pkg::*;
#(
   parameter int                ADDR_W    = JC_ADDR_W,
   parameter int                N_IRQ     = JC_N_IRQ,
   parameter int                RAS_DEPTH = JC_RAS_DEPTH,
   parameter logic [ADDR_W-1:0] VEC_BASE  = JC_VEC_BASE
) (
   input  logic            clk,
   input  logic            reset,
   jump_ctrl_unit_if.slave bus
);

   jc_state_t         state, state_next;
   logic [N_IRQ-1:0]  pending, pending_next, irq_prev, rise, cand, take_oh, ack_next;
   logic [ADDR_W-1:0] jmp_next, vec_addr, ret_addr;
   logic [1:0]        fr_next;
   logic              pc_next, fre_next, in_isr_next, err_next;
   logic              push, pop, ras_full, ras_empty;
   ras_entry_t        push_entry, top_entry;

   jc_ras #(
      .DATA_W ($bits(ras_entry_t)),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .pop       (pop),
      .push_data (push_entry),
      .top_data  (top_entry),
      .full      (ras_full),
      .empty     (ras_empty)
   );

   // A fresh edge this cycle is already eligible, so an irq rising alongside an op pre-empts it.
   always_comb begin
      rise         = bus.irq & ~irq_prev;
      cand         = pending | rise;
      pending_next = (pending & ~bus.irq_ack) | rise;
      take_oh      = cand & (~cand + N_IRQ'(1));
      vec_addr     = VEC_BASE;
      for (int k = N_IRQ - 1; k >= 0; k--) begin
         if (cand[k]) vec_addr = VEC_BASE + ADDR_W'(k);
      end
      ret_addr     = bus.current_address + ADDR_W'(1);

      jmp_next    = bus.jmp_loc;
      fr_next     = bus.flag_restore;
      in_isr_next = bus.in_isr;
      err_next    = bus.ras_err;
      pc_next     = 1'b0;
      fre_next    = 1'b0;
      ack_next    = '0;
      push        = 1'b0;
      pop         = 1'b0;
      push_entry  = '0;

      case (state)
         ST_RUN: begin
            if (!bus.in_isr && (|cand) && !ras_full) begin
               push        = 1'b1;
               push_entry  = '{flags: bus.flag_ex, addr: bus.current_address};
               jmp_next    = vec_addr;
               pc_next     = 1'b1;
               ack_next    = take_oh;
               in_isr_next = 1'b1;
            end else begin
               case (bus.op)
                  OP_JMP: begin
                     jmp_next = bus.jmp_address_pm;
                     pc_next  = 1'b1;
                  end
                  OP_JC: begin
                     if (bus.flag_ex[0]) begin
                        jmp_next = bus.jmp_address_pm;
                        pc_next  = 1'b1;
                     end
                  end
                  OP_JZ: begin
                     if (bus.flag_ex[1]) begin
                        jmp_next = bus.jmp_address_pm;
                        pc_next  = 1'b1;
                     end
                  end
                  OP_CALL: begin
                     if (ras_full) begin
                        err_next = 1'b1;
                     end else begin
                        push       = 1'b1;
                        push_entry = '{flags: 2'b00, addr: ret_addr};
                     end
                     jmp_next = bus.jmp_address_pm;
                     pc_next  = 1'b1;
                  end
                  OP_RET, OP_RETI: begin
                     pc_next = 1'b1;
                     if (ras_empty) begin
                        err_next = 1'b1;
                        jmp_next = '0;
                     end else begin
                        pop      = 1'b1;
                        jmp_next = top_entry.addr;
                     end
                     if (bus.op == OP_RETI) begin
                        fre_next    = 1'b1;
                        fr_next     = ras_empty ? 2'b00 : top_entry.flags;
                        in_isr_next = 1'b0;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: ;
      endcase

      state_next = pc_next ? ST_FLUSH : ST_RUN;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state               <= ST_RUN;
         pending             <= '0;
         irq_prev            <= '0;
         bus.jmp_loc         <= '0;
         bus.pc_mux_sel      <= 1'b0;
         bus.irq_ack         <= '0;
         bus.flag_restore    <= 2'b00;
         bus.flag_restore_en <= 1'b0;
         bus.in_isr          <= 1'b0;
         bus.ras_err         <= 1'b0;
      end else begin
         state               <= state_next;
         pending             <= pending_next;
         irq_prev            <= bus.irq;
         bus.jmp_loc         <= jmp_next;
         bus.pc_mux_sel      <= pc_next;
         bus.irq_ack         <= ack_next;
         bus.flag_restore    <= fr_next;
         bus.flag_restore_en <= fre_next;
         bus.in_isr          <= in_isr_next;
         bus.ras_err         <= err_next;
      end
   end

endmodule

// File: tb/tb_jump_ctrl_unit.sv
// Scoreboard bench for jump_ctrl_unit: directed scenarios then random traffic,
// each cycle's expected outputs come from a queue-based reference model.
module tb_jump_ctrl_unit;
   import jc_pkg::*;

   typedef struct packed {
      logic [15:0] jmp_loc;
      logic        pc;
      logic [3:0]  ack;
      logic [1:0]  fr;
      logic        fre;
      logic        isr;
      logic        err;
   } resp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   jump_ctrl_unit_if #(.ADDR_W(16), .N_IRQ(4)) bus ();

   jump_ctrl_unit #(
      .ADDR_W    (16),
      .N_IRQ     (4),
      .RAS_DEPTH (4),
      .VEC_BASE  (16'hFF00)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   resp_t       exp_q[$];
   int          vectors     = 0;
   int          miscompares = 0;

   // Reference model state: the return stack is a plain queue, top at the back.
   logic [17:0] m_stack[$];
   logic [3:0]  m_pend  = '0;
   logic [3:0]  m_prev  = '0;
   logic        m_flush = 1'b0;
   resp_t       m_out   = '0;

   function automatic void modelStep(input logic rst_n, input logic [5:0] op,
                                     input logic [15:0] cur, input logic [15:0] tgt,
                                     input logic [1:0] fl, input logic [3:0] irq);
      logic [3:0]  rise, avail;
      logic [17:0] e;
      resp_t       nxt;
      int          k;
      if (!rst_n) begin
         m_stack.delete();
         m_pend  = '0;
         m_prev  = '0;
         m_flush = 1'b0;
         m_out   = '0;
         return;
      end
      rise  = irq & ~m_prev;
      avail = m_pend | rise;
      nxt     = m_out;
      nxt.pc  = 1'b0;
      nxt.ack = '0;
      nxt.fre = 1'b0;
      if (!m_flush) begin
         if (!m_out.isr && avail != 0 && m_stack.size() < 4) begin
            k = 0;
            while (!avail[k]) k++;
            m_stack.push_back({fl, cur});
            nxt.jmp_loc = 16'hFF00 + 16'(k);
            nxt.pc      = 1'b1;
            nxt.ack     = 4'(1 << k);
            nxt.isr     = 1'b1;
         end else begin
            case (op)
               OP_JMP: begin nxt.jmp_loc = tgt; nxt.pc = 1'b1; end
               OP_JC:  if (fl[0]) begin nxt.jmp_loc = tgt; nxt.pc = 1'b1; end
               OP_JZ:  if (fl[1]) begin nxt.jmp_loc = tgt; nxt.pc = 1'b1; end
               OP_CALL: begin
                  if (m_stack.size() < 4) m_stack.push_back({2'b00, 16'(cur + 16'd1)});
                  else nxt.err = 1'b1;
                  nxt.jmp_loc = tgt;
                  nxt.pc      = 1'b1;
               end
               OP_RET, OP_RETI: begin
                  if (m_stack.size() > 0) e = m_stack.pop_back();
                  else begin e = '0; nxt.err = 1'b1; end
                  nxt.jmp_loc = e[15:0];
                  nxt.pc      = 1'b1;
                  if (op == OP_RETI) begin
                     nxt.fr  = e[17:16];
                     nxt.fre = 1'b1;
                     nxt.isr = 1'b0;
                  end
               end
               default: ;
            endcase
         end
      end
      m_pend  = (m_pend & ~m_out.ack) | rise;
      m_prev  = irq;
      m_flush = nxt.pc;
      m_out   = nxt;
   endfunction

   task automatic applyStimulus(input logic rst_n, input logic [5:0] op,
                                input logic [15:0] cur, input logic [15:0] tgt,
                                input logic [1:0] fl, input logic [3:0] irq);
      @(negedge clk);
      reset               = rst_n;
      bus.op              = op;
      bus.current_address = cur;
      bus.jmp_address_pm  = tgt;
      bus.flag_ex         = fl;
      bus.irq             = irq;
      modelStep(rst_n, op, cur, tgt, fl, irq);
      exp_q.push_back(m_out);
   endtask

   task automatic checkOutput(input resp_t e);
      resp_t a;
      a = '{jmp_loc: bus.jmp_loc, pc: bus.pc_mux_sel, ack: bus.irq_ack,
            fr: bus.flag_restore, fre: bus.flag_restore_en, isr: bus.in_isr, err: bus.ras_err};
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("[TB] FAIL cycle_resp @%0t: got jmp_loc=%h pc=%b ack=%b fr=%b fre=%b isr=%b err=%b, expected jmp_loc=%h pc=%b ack=%b fr=%b fre=%b isr=%b err=%b",
                  $time, a.jmp_loc, a.pc, a.ack, a.fr, a.fre, a.isr, a.err,
                  e.jmp_loc, e.pc, e.ack, e.fr, e.fre, e.isr, e.err);
      end
   endtask

   // Monitor: one expected response per clock edge, sampled just after the edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
      end
   end

   initial begin
      logic [5:0]  r_op;
      logic [15:0] r_cur;
      logic [3:0]  r_irq;
      logic        r_rst;
      bus.op              = '0;
      bus.current_address = '0;
      bus.jmp_address_pm  = '0;
      bus.flag_ex         = '0;
      bus.irq             = '0;
      $display("[TB] start");

      applyStimulus(0, 6'd0, 16'h0000, 16'h0000, 2'b00, 4'h0);
      applyStimulus(0, 6'd0, 16'h0000, 16'h0000, 2'b00, 4'h0);
      // JMP then a JMP that lands in the flush slot
      applyStimulus(1, OP_JMP, 16'h0002, 16'h0008, 2'b00, 4'h0);
      applyStimulus(1, OP_JMP, 16'h0003, 16'h0030, 2'b00, 4'h0);
      applyStimulus(1, OP_JZ,  16'h0008, 16'h0050, 2'b00, 4'h0);
      applyStimulus(1, OP_JZ,  16'h0009, 16'h0060, 2'b10, 4'h0);
      applyStimulus(1, 6'd0,   16'h000A, 16'h0000, 2'b00, 4'h0);
      applyStimulus(1, OP_JC,  16'h0060, 16'h0070, 2'b01, 4'h0);
      applyStimulus(1, 6'd0,   16'h0061, 16'h0000, 2'b00, 4'h0);
      // CALL / RET pair
      applyStimulus(1, OP_CALL, 16'h0010, 16'h0040, 2'b11, 4'h0);
      applyStimulus(1, 6'd0,    16'h0011, 16'h0000, 2'b00, 4'h0);
      applyStimulus(1, OP_RET,  16'h0040, 16'h0000, 2'b00, 4'h0);
      applyStimulus(1, 6'd0,    16'h0041, 16'h0000, 2'b00, 4'h0);
      // Two irqs rising with a CALL; lower channel first, then the held one
      applyStimulus(1, OP_CALL, 16'h0020, 16'h0090, 2'b01, 4'b0110);
      applyStimulus(1, 6'd0,    16'h0021, 16'h0000, 2'b00, 4'b0110);
      applyStimulus(1, 6'd0,    16'hFF01, 16'h0000, 2'b00, 4'b0110);
      applyStimulus(1, OP_RETI, 16'hFF02, 16'h0000, 2'b00, 4'b0110);
      applyStimulus(1, 6'd0,    16'hFF03, 16'h0000, 2'b00, 4'b0110);
      applyStimulus(1, 6'd0,    16'h0020, 16'h0000, 2'b10, 4'b0110);
      applyStimulus(1, 6'd0,    16'h0021, 16'h0000, 2'b00, 4'b0110);
      applyStimulus(1, OP_RETI, 16'hFF02, 16'h0000, 2'b00, 4'b0000);
      applyStimulus(1, 6'd0,    16'h0020, 16'h0000, 2'b00, 4'b0000);
      // Overflow: five calls, then an irq held off until a RET frees a slot
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1, OP_CALL, 16'(16'h0100 + i), 16'(16'h0200 + i), 2'b00, 4'h0);
         applyStimulus(1, 6'd0,    16'h0000, 16'h0000, 2'b00, 4'h0);
      end
      applyStimulus(1, 6'd0,   16'h0300, 16'h0000, 2'b01, 4'b0001);
      applyStimulus(1, 6'd0,   16'h0301, 16'h0000, 2'b01, 4'b0001);
      applyStimulus(1, OP_RET, 16'h0302, 16'h0000, 2'b01, 4'b0001);
      applyStimulus(1, 6'd0,   16'h0303, 16'h0000, 2'b01, 4'b0001);
      applyStimulus(1, 6'd0,   16'h0304, 16'h0000, 2'b11, 4'b0001);
      applyStimulus(1, 6'd0,   16'h0305, 16'h0000, 2'b00, 4'b0001);
      // Reset mid-ISR with irq held high, then underflow and a clean reset
      applyStimulus(0, 6'd0,   16'h0000, 16'h0000, 2'b00, 4'b0001);
      applyStimulus(1, 6'd0,   16'h0400, 16'h0000, 2'b10, 4'b0001);
      applyStimulus(1, 6'd0,   16'h0401, 16'h0000, 2'b00, 4'b0000);
      applyStimulus(1, OP_RETI,16'hFF00, 16'h0000, 2'b00, 4'b0000);
      applyStimulus(1, 6'd0,   16'h0402, 16'h0000, 2'b00, 4'b0000);
      applyStimulus(1, OP_RET, 16'h0500, 16'h0000, 2'b00, 4'b0000);
      applyStimulus(1, 6'd0,   16'h0501, 16'h0000, 2'b00, 4'b0000);
      applyStimulus(0, 6'd0,   16'h0000, 16'h0000, 2'b00, 4'b0000);
      applyStimulus(1, 6'd0,   16'h0000, 16'h0000, 2'b00, 4'b0000);

      // Random traffic biased towards control-flow opcodes
      r_irq = '0;
      for (int i = 0; i < 2000; i++) begin
         case ($urandom_range(0, 9))
            0:       r_op = OP_JMP;
            1:       r_op = OP_JC;
            2:       r_op = OP_JZ;
            3, 4:    r_op = OP_CALL;
            5:       r_op = OP_RET;
            6, 7:    r_op = OP_RETI;
            8:       r_op = 6'd0;
            default: r_op = 6'($urandom);
         endcase
         r_cur = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
         if ($urandom_range(0, 5) == 0) r_irq = r_irq ^ 4'(1 << $urandom_range(0, 3));
         r_rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         applyStimulus(r_rst, r_op, r_cur, 16'($urandom), 2'($urandom), r_irq);
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("[TB] FAIL drain: %0d responses left unchecked, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
